addsub_pipe: RTL

Parametrised, pipelined signed/unsigned add/subtract unit with valid/ready handshaking on both sides, multi-word carry/borrow chaining, optional signed saturation and status flags. It is the next-generation replacement for the fixed-width registered add/sub block. It sits between an operand source and a result consumer on the shared `as_inf`-style datapath and tolerates back-pressure without losing or reordering transactions.

---
 rtl/addsub_pkg.sv | 47 ++++
 rtl/addsub_pipe_stage.sv | 50 +++++
 rtl/addsub_pipe.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
// Shared types and helpers for the pipelined add/subtract unit.
//   addsub_op_e    : operation encoding carried with each transaction
//   addsub_flags_t : status flags {c, v, n, z} travelling with each result
//   is_sub_op      : true when operand B is inverted (subtract forms)
//   uses_carry_op  : true when carry-in comes from the chained carry register
// ---------------------------------------------------------------------------
package addsub_pkg;

    localparam int FLAGS_W = 4;

    typedef enum logic [1:0] {
        ADD  = 2'd0,
        SUB  = 2'd1,
        ADDC = 2'd2,
        SUBB = 2'd3
    } addsub_op_e;

    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } addsub_flags_t;

    function automatic logic is_sub_op(input addsub_op_e op);
        logic res;
        case (op)
            SUB, SUBB: res = 1'b1;
            ADD, ADDC: res = 1'b0;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic uses_carry_op(input addsub_op_e op);
        logic res;
        case (op)
            ADDC, SUBB: res = 1'b1;
            ADD, SUB:   res = 1'b0;
            default:    res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/addsub_pipe_stage.sv
// ---------------------------------------------------------------------------
// addsub_pipe_stage
// One valid/ready register slice. Loads when empty or when its current
// contents leave on the same edge, so a chain of slices runs at full rate
// and bubbles collapse.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   upstream handshake
//   in_data [PW-1:0]      upstream payload
//   out_valid / out_ready downstream handshake
//   out_data [PW-1:0]     registered payload
// ---------------------------------------------------------------------------
module addsub_pipe_stage #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    logic          valid_r;
    logic [PW-1:0] data_r;
    logic          load_s;

    assign in_ready  = !valid_r || out_ready;
    assign load_s    = in_valid && in_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Slice occupancy and payload register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= {PW{1'b0}};
        end else begin
            if (in_ready) begin
                valid_r <= in_valid;
            end
            if (load_s) begin
                data_r <= in_data;
            end
        end
    end

endmodule

// File: rtl/addsub_pipe.sv
// ---------------------------------------------------------------------------
// addsub_pipe
// Pipelined add/subtract unit with carry/borrow chaining, optional signed
// saturation and {C,V,N,Z} flags. Slice 1 captures the operands; the
// arithmetic sits between slice 1 and slice 2; further slices only delay.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid / in_ready        operand handshake
//   opcode[1:0], sat_en        operation and saturation enable
//   a_in, b_in [WIDTH-1:0]     operands
//   out_valid / out_ready      result handshake
//   result [WIDTH-1:0]         registered result
//   flags [3:0]                {C, V, N, Z} aligned with result
// ---------------------------------------------------------------------------
import addsub_pkg::*;

module addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       opcode,
    input  logic             sat_en,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int S1W = 2 + 1 + 2 * WIDTH;     // {opcode, sat_en, a, b}
    localparam int SNW = WIDTH + FLAGS_W;       // {result, flags}
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // vld_s[k]/rdy_s[k]: handshake into slice k; index STAGES is the output port
    logic           vld_s [STAGES+1];
    logic           rdy_s [STAGES+1];
    logic [SNW-1:0] dat_s [1:STAGES];

    logic [S1W-1:0] s1_din_s;
    logic [S1W-1:0] s1_dout_s;

    addsub_op_e      op_s;
    logic            sat_s;
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH-1:0] b_eff_s;
    logic            cin_s;
    logic [WIDTH:0]  raw_s;
    logic            ovf_s;
    logic [WIDTH-1:0] res_s;
    addsub_flags_t   flg_s;
    logic            carry_r;

    assign s1_din_s = {opcode, sat_en, a_in, b_in};

    assign vld_s[0]      = in_valid;
    assign in_ready      = rdy_s[0];
    assign rdy_s[STAGES] = out_ready;
    assign out_valid     = vld_s[STAGES];
    assign result        = dat_s[STAGES][SNW-1:FLAGS_W];
    assign flags         = dat_s[STAGES][FLAGS_W-1:0];

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_first
                addsub_pipe_stage #(.PW(S1W)) u_stage (
                    .clk       (clk),
                    .reset     (reset),
                    .in_valid  (vld_s[0]),
                    .in_ready  (rdy_s[0]),
                    .in_data   (s1_din_s),
                    .out_valid (vld_s[1]),
                    .out_ready (rdy_s[1]),
                    .out_data  (s1_dout_s)
                );
            end else begin : g_rest
                addsub_pipe_stage #(.PW(SNW)) u_stage (
                    .clk       (clk),
                    .reset     (reset),
                    .in_valid  (vld_s[k]),
                    .in_ready  (rdy_s[k]),
                    .in_data   (dat_s[k]),
                    .out_valid (vld_s[k+1]),
                    .out_ready (rdy_s[k+1]),
                    .out_data  (dat_s[k+1])
                );
            end
        end
    endgenerate

    assign op_s  = addsub_op_e'(s1_dout_s[S1W-1 -: 2]);
    assign sat_s = s1_dout_s[2*WIDTH];
    assign a_s   = s1_dout_s[2*WIDTH-1 -: WIDTH];
    assign b_s   = s1_dout_s[WIDTH-1:0];

    // Add/subtract, overflow detection, saturation and flag generation
    always_comb begin
        b_eff_s = b_s;
        cin_s   = 1'b0;
        if (is_sub_op(op_s)) begin
            b_eff_s = ~b_s;
        end else begin
            b_eff_s = b_s;
        end
        // Plain SUB supplies the +1 of two's complement; chained forms take the stored carry
        if (uses_carry_op(op_s)) begin
            cin_s = carry_r;
        end else begin
            cin_s = is_sub_op(op_s);
        end
        raw_s = {1'b0, a_s} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_s};
        // Signed overflow: like-signed addends producing a differently-signed sum
        ovf_s = (a_s[WIDTH-1] == b_eff_s[WIDTH-1]) && (raw_s[WIDTH-1] != a_s[WIDTH-1]);
        if (sat_s && ovf_s) begin
            if (a_s[WIDTH-1]) begin
                res_s = SMIN;
            end else begin
                res_s = SMAX;
            end
        end else begin
            res_s = raw_s[WIDTH-1:0];
        end
        flg_s.c = raw_s[WIDTH];
        flg_s.v = ovf_s;
        flg_s.n = res_s[WIDTH-1];
        flg_s.z = (res_s == {WIDTH{1'b0}});
        dat_s[1] = {res_s, flg_s};
    end

    // Chained carry: captured as each op leaves slice 1, so it always belongs
    // to the op accepted immediately before the one now in slice 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_r <= 1'b0;
        end else if (vld_s[1] && rdy_s[1]) begin
            carry_r <= raw_s[WIDTH];
        end
    end

endmodule
